// File: rtl/cc_stim_driver.sv
// -----------------------------------------------------------------------------
// cc_stim_driver
//
// Transmitter for the CC candy-board input protocol. Accepts one packed
// 223-bit pattern word, replays it as the 36-cycle board phase
// (in_valid_1), idles GAP_CYCLES cycles, replays the 10-cycle action phase
// (in_valid_2), then waits for the CC core's single-cycle score strobe,
// compares it against the expected score and keeps saturating pass/fail
// tallies. Intended for on-chip/FPGA self-test of CC and as a bench driver.
//
// Optional feature macro: CC_STIM_PROTO_CHECK_EN
//   Defined   -> sticky proto_err flags illegal out_valid/out_score behaviour.
//   Undefined -> checker absent, proto_err tied to 0.
//
// Parameters:
//   GAP_CYCLES  idle cycles between the board and action phases (1..15)
//   TIMEOUT     cycles allowed for the score response (2..1023)
//   CNT_W       width of the saturating pass/fail counters
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   pat_valid/ready     pattern handshake (ready only in IDLE)
//   pat_data[222:0]     packed pattern, item 0 of every field at the MSB end
//   in_valid_1/2        board / action phase valids towards CC
//   in_color            candy colour (board phase)
//   in_starting_pos     {row, col}: board items 0-3 or action phase
//   in_stripe           stripe type (board items 0-3)
//   in_action           action code (action phase)
//   out_valid/score     CC score response
//   res_valid           one-cycle result strobe
//   res_pass            score matched and no timeout
//   res_timeout         no response within TIMEOUT
//   res_score           captured score (0 on timeout)
//   pass_count          saturating pass tally
//   fail_count          saturating fail tally (mismatch or timeout)
//   proto_err           sticky protocol error flag
// -----------------------------------------------------------------------------
module cc_stim_driver #(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 500,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [222:0]     pat_data,
    output logic             in_valid_1,
    output logic             in_valid_2,
    output logic [2:0]       in_color,
    output logic [5:0]       in_starting_pos,
    output logic             in_stripe,
    output logic [1:0]       in_action,
    input  logic             out_valid,
    input  logic [6:0]       out_score,
    output logic             res_valid,
    output logic             res_pass,
    output logic             res_timeout,
    output logic [6:0]       res_score,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             proto_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CANDY,
        S_GAP,
        S_ACTION,
        S_WAIT,
        S_REPORT
    } state_t;

    state_t       state;
    logic [222:0] shadow;
    logic [5:0]   cidx;      // board item currently on the outputs
    logic [3:0]   aidx;      // action item currently on the outputs
    logic [3:0]   gap_cnt;
    logic [9:0]   wait_cnt;

    logic resp_match;
    logic pass_sat;
    logic fail_sat;

    // Field extraction: item k of each field sits 'k' slots below the MSB of
    // that field's slice.
    function automatic logic [2:0] colour_at(input logic [222:0] w, input int k);
        return w[222 - 3*k -: 3];
    endfunction

    function automatic logic [5:0] spos_at(input logic [222:0] w, input int k);
        return {w[114 - 3*k -: 3], w[102 - 3*k -: 3]};
    endfunction

    function automatic logic stype_at(input logic [222:0] w, input int k);
        return w[90 - k];
    endfunction

    function automatic logic [5:0] apos_at(input logic [222:0] w, input int k);
        return {w[86 - 3*k -: 3], w[56 - 3*k -: 3]};
    endfunction

    function automatic logic [1:0] act_at(input logic [222:0] w, input int k);
        return w[26 - 2*k -: 2];
    endfunction

    assign resp_match = (out_score == shadow[6:0]);
    assign pass_sat   = (pass_count == {CNT_W{1'b1}});
    assign fail_sat   = (fail_count == {CNT_W{1'b1}});

    // NOTE: the pattern shadow is plain data qualified by the FSM, so it has no
    // reset; it only loads on acceptance, which keeps it off the reset tree.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && pat_valid) begin
            shadow <= pat_data;
        end
    end

    // NOTE: every register here uses <= so all next-state values are computed
    // from the pre-edge state; a blocking '=' would leak updates between lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            pat_ready       <= 1'b1;
            in_valid_1      <= 1'b0;
            in_valid_2      <= 1'b0;
            in_color        <= 3'd0;
            in_starting_pos <= 6'd0;
            in_stripe       <= 1'b0;
            in_action       <= 2'd0;
            res_valid       <= 1'b0;
            res_pass        <= 1'b0;
            res_timeout     <= 1'b0;
            res_score       <= 7'd0;
            pass_count      <= '0;
            fail_count      <= '0;
            cidx            <= 6'd0;
            aidx            <= 4'd0;
            gap_cnt         <= 4'd0;
            wait_cnt        <= 10'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pat_valid) begin
                        // Item 0 goes out straight from pat_data; the shadow
                        // is loading on this same edge.
                        state           <= S_CANDY;
                        pat_ready       <= 1'b0;
                        cidx            <= 6'd0;
                        in_valid_1      <= 1'b1;
                        in_color        <= colour_at(pat_data, 0);
                        in_starting_pos <= spos_at(pat_data, 0);
                        in_stripe       <= stype_at(pat_data, 0);
                    end
                end

                S_CANDY: begin
                    if (cidx == 6'd35) begin
                        state      <= S_GAP;
                        gap_cnt    <= 4'd0;
                        in_valid_1 <= 1'b0;
                        in_color   <= 3'd0;
                    end else begin
                        cidx     <= cidx + 6'd1;
                        in_color <= colour_at(shadow, int'(cidx) + 1);
                        // Stripe info accompanies only board items 0-3.
                        if (cidx < 6'd3) begin
                            in_starting_pos <= spos_at(shadow, int'(cidx) + 1);
                            in_stripe       <= stype_at(shadow, int'(cidx) + 1);
                        end else begin
                            in_starting_pos <= 6'd0;
                            in_stripe       <= 1'b0;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
                        state           <= S_ACTION;
                        aidx            <= 4'd0;
                        in_valid_2      <= 1'b1;
                        in_starting_pos <= apos_at(shadow, 0);
                        in_action       <= act_at(shadow, 0);
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end

                S_ACTION: begin
                    if (aidx == 4'd9) begin
                        state           <= S_WAIT;
                        wait_cnt        <= 10'd0;
                        in_valid_2      <= 1'b0;
                        in_starting_pos <= 6'd0;
                        in_action       <= 2'd0;
                    end else begin
                        aidx            <= aidx + 4'd1;
                        in_starting_pos <= apos_at(shadow, int'(aidx) + 1);
                        in_action       <= act_at(shadow, int'(aidx) + 1);
                    end
                end

                S_WAIT: begin
                    // A response on the terminal-count cycle still counts as a
                    // response, so out_valid is tested first.
                    if (out_valid) begin
                        state       <= S_REPORT;
                        res_valid   <= 1'b1;
                        res_pass    <= resp_match;
                        res_timeout <= 1'b0;
                        res_score   <= out_score;
                        if (resp_match) begin
                            if (!pass_sat) pass_count <= pass_count + CNT_W'(1);
                        end else begin
                            if (!fail_sat) fail_count <= fail_count + CNT_W'(1);
                        end
                    end else if (wait_cnt == 10'(TIMEOUT - 1)) begin
                        state       <= S_REPORT;
                        res_valid   <= 1'b1;
                        res_pass    <= 1'b0;
                        res_timeout <= 1'b1;
                        res_score   <= 7'd0;
                        if (!fail_sat) fail_count <= fail_count + CNT_W'(1);
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end

                S_REPORT: begin
                    state       <= S_IDLE;
                    pat_ready   <= 1'b1;
                    res_valid   <= 1'b0;
                    res_pass    <= 1'b0;
                    res_timeout <= 1'b0;
                    res_score   <= 7'd0;
                end

                default: begin
                    state     <= S_IDLE;
                    pat_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef CC_STIM_PROTO_CHECK_EN
    logic out_valid_q;

    // Sticky flag: back-to-back strobes, a score without a strobe, or a
    // strobe while no response is expected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            out_valid_q <= out_valid;
            if ((out_valid && out_valid_q) ||
                (!out_valid && out_score != 7'd0) ||
                (out_valid && state != S_WAIT)) begin
                proto_err <= 1'b1;
            end
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_cc_stim_driver.sv
// -----------------------------------------------------------------------------
// tb_cc_stim_driver
//
// Directed self-checking bench for cc_stim_driver. Builds pattern words from
// small per-field tables, checks the replayed waveform cycle by cycle, and
// exercises pass, mismatch, timeout, terminal-count response, stray strobes,
// mid-pattern reset and the optional protocol checker.
// -----------------------------------------------------------------------------
module tb_cc_stim_driver;

    localparam int TO   = 20;
    localparam int GAP  = 2;
    localparam int CW   = 8;

    logic          clk;
    logic          rst_n;
    logic          pat_valid;
    logic          pat_ready;
    logic [222:0]  pat_data;
    logic          in_valid_1;
    logic          in_valid_2;
    logic [2:0]    in_color;
    logic [5:0]    in_starting_pos;
    logic          in_stripe;
    logic [1:0]    in_action;
    logic          out_valid;
    logic [6:0]    out_score;
    logic          res_valid;
    logic          res_pass;
    logic          res_timeout;
    logic [6:0]    res_score;
    logic [CW-1:0] pass_count;
    logic [CW-1:0] fail_count;
    logic          proto_err;

    cc_stim_driver #(
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TO),
        .CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pat_valid       (pat_valid),
        .pat_ready       (pat_ready),
        .pat_data        (pat_data),
        .in_valid_1      (in_valid_1),
        .in_valid_2      (in_valid_2),
        .in_color        (in_color),
        .in_starting_pos (in_starting_pos),
        .in_stripe       (in_stripe),
        .in_action       (in_action),
        .out_valid       (out_valid),
        .out_score       (out_score),
        .res_valid       (res_valid),
        .res_pass        (res_pass),
        .res_timeout     (res_timeout),
        .res_score       (res_score),
        .pass_count      (pass_count),
        .fail_count      (fail_count),
        .proto_err       (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-field stimulus tables (item 0 first).
    logic [2:0] col_t [36];
    logic [2:0] srow_t[4];
    logic [2:0] scol_t[4];
    logic       styp_t[4];
    logic [2:0] arow_t[10];
    logic [2:0] acol_t[10];
    logic [1:0] act_t [10];

    task automatic init_tables();
        for (int k = 0; k < 36; k++) col_t[k] = 3'((k * 3 + 1) % 8);
        for (int k = 0; k < 4; k++) begin
            srow_t[k] = 3'(k + 1);
            scol_t[k] = 3'(6 - k);
        end
        styp_t[0] = 1'b1; styp_t[1] = 1'b1; styp_t[2] = 1'b0; styp_t[3] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            arow_t[j] = 3'((j + 2) % 8);
            acol_t[j] = 3'((j * 5 + 1) % 8);
            act_t[j]  = 2'((j + 1) % 4);
        end
    endtask

    // Appends fields in wire order so the first field ends up at the MSBs.
    function automatic logic [222:0] build_pat(input logic [6:0] exp_score);
        logic [222:0] w;
        w = '0;
        for (int k = 0; k < 36; k++) w = {w[219:0], col_t[k]};
        for (int k = 0; k < 4; k++)  w = {w[219:0], srow_t[k]};
        for (int k = 0; k < 4; k++)  w = {w[219:0], scol_t[k]};
        for (int k = 0; k < 4; k++)  w = {w[221:0], styp_t[k]};
        for (int j = 0; j < 10; j++) w = {w[219:0], arow_t[j]};
        for (int j = 0; j < 10; j++) w = {w[219:0], acol_t[j]};
        for (int j = 0; j < 10; j++) w = {w[220:0], act_t[j]};
        w = {w[215:0], exp_score};
        return w;
    endfunction

    // Offers a pattern and returns at the first negedge after acceptance
    // (board item 0 on the outputs). pat_data is then scrambled.
    task automatic send_pattern(input logic [222:0] w);
        @(negedge clk);
        check("pat_ready_before_send", pat_ready, 1);
        pat_valid = 1'b1;
        pat_data  = w;
        @(negedge clk);
        pat_valid = 1'b0;
        pat_data  = ~w;
    endtask

    // From the last action-item negedge: wait d cycles, pulse out_valid for one
    // cycle, and return at the negedge where REPORT should be visible.
    task automatic respond(input int d, input logic [6:0] s);
        repeat (d) @(negedge clk);
        check("no_early_res_valid", res_valid, 0);
        out_valid = 1'b1;
        out_score = s;
        @(negedge clk);
        out_valid = 1'b0;
        out_score = 7'd0;
    endtask

    task automatic check_report_gone();
        @(negedge clk);
        check("res_valid_one_cycle", res_valid, 0);
        check("pat_ready_after_report", pat_ready, 1);
    endtask

    logic [31:0] exp_proto_stray;

    initial begin
        logic [222:0] pa;
        logic [5:0]   exp_pos;
        int           k;
        int           rv_seen;

`ifdef CC_STIM_PROTO_CHECK_EN
        exp_proto_stray = 1;
`else
        exp_proto_stray = 0;
`endif

        init_tables();
        rst_n     = 1'b0;
        pat_valid = 1'b0;
        pat_data  = '0;
        out_valid = 1'b0;
        out_score = 7'd0;
        pa        = build_pat(7'd42);

        // ---- Reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pat_ready", pat_ready, 1);
        check("rst_in_valid_1", in_valid_1, 0);
        check("rst_in_valid_2", in_valid_2, 0);
        check("rst_in_color", in_color, 0);
        check("rst_in_pos", in_starting_pos, 0);
        check("rst_in_stripe", in_stripe, 0);
        check("rst_in_action", in_action, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_pass", res_pass, 0);
        check("rst_res_timeout", res_timeout, 0);
        check("rst_res_score", res_score, 0);
        check("rst_pass_count", pass_count, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_proto_err", proto_err, 0);
        rst_n = 1'b1;

        // ---- Timing / field check, correct response (42 vs 42) ----
        send_pattern(pa);
        for (int e = 1; e <= 48; e++) begin
            if (e > 1) @(negedge clk);
            check($sformatf("iv1_e%0d", e), in_valid_1, (e <= 36) ? 1 : 0);
            check($sformatf("iv2_e%0d", e), in_valid_2, (e >= 39) ? 1 : 0);
            check($sformatf("color_e%0d", e), in_color, (e <= 36) ? 32'(col_t[e-1]) : 0);
            if (e <= 4)        exp_pos = {srow_t[e-1], scol_t[e-1]};
            else if (e >= 39)  exp_pos = {arow_t[e-39], acol_t[e-39]};
            else               exp_pos = 6'd0;
            check($sformatf("pos_e%0d", e), in_starting_pos, exp_pos);
            check($sformatf("stripe_e%0d", e), in_stripe, (e <= 4) ? 32'(styp_t[e-1]) : 0);
            check($sformatf("action_e%0d", e), in_action, (e >= 39) ? 32'(act_t[e-39]) : 0);
        end
        @(negedge clk);
        check("iv2_low_after_e48", in_valid_2, 0);
        check("pos_low_after_e48", in_starting_pos, 0);
        respond(2, 7'd42);
        check("pass_res_valid", res_valid, 1);
        check("pass_res_pass", res_pass, 1);
        check("pass_res_timeout", res_timeout, 0);
        check("pass_res_score", res_score, 42);
        check("pass_pass_count", pass_count, 1);
        check("pass_fail_count", fail_count, 0);
        check_report_gone();

        // ---- Mismatch (41 vs 42) ----
        send_pattern(pa);
        repeat (47) @(negedge clk);
        respond(5, 7'd41);
        check("mis_res_valid", res_valid, 1);
        check("mis_res_pass", res_pass, 0);
        check("mis_res_score", res_score, 41);
        check("mis_res_timeout", res_timeout, 0);
        check("mis_fail_count", fail_count, 1);
        check("mis_pass_count", pass_count, 1);
        check_report_gone();

        // ---- Timeout: no response ----
        send_pattern(pa);
        repeat (47) @(negedge clk);
        k = 0;
        while (k < TO + 10) begin
            @(negedge clk);
            k++;
            if (res_valid) break;
        end
        // First negedge with in_valid_2 low is k = 1; REPORT TO cycles later.
        check("to_latency", k, TO + 1);
        check("to_res_timeout", res_timeout, 1);
        check("to_res_pass", res_pass, 0);
        check("to_res_score", res_score, 0);
        check("to_fail_count", fail_count, 2);
        check_report_gone();

        // ---- Response on the terminal-count cycle ----
        send_pattern(pa);
        repeat (47) @(negedge clk);
        respond(TO, 7'd42);
        check("tc_res_valid", res_valid, 1);
        check("tc_res_timeout", res_timeout, 0);
        check("tc_res_pass", res_pass, 1);
        check("tc_pass_count", pass_count, 2);
        check("tc_fail_count", fail_count, 2);
        check_report_gone();
        check("proto_clean_so_far", proto_err, 0);

        // ---- Stray out_valid in IDLE is ignored by the FSM ----
        out_valid = 1'b1;
        out_score = 7'd42;
        @(negedge clk);
        out_valid = 1'b0;
        out_score = 7'd0;
        rv_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (res_valid) rv_seen++;
        end
        check("stray_no_res_valid", rv_seen, 0);
        check("stray_pat_ready", pat_ready, 1);
        check("stray_pass_count", pass_count, 2);
        check("stray_proto_err", proto_err, exp_proto_stray);

        // ---- Reset during ACTION item 5 ----
        send_pattern(pa);
        repeat (43) @(negedge clk);
        check("mid_iv2_at_j5", in_valid_2, 1);
        check("mid_action_j5", in_action, act_t[5]);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_iv2_dropped", in_valid_2, 0);
        check("mid_iv1_low", in_valid_1, 0);
        check("mid_pos_zero", in_starting_pos, 0);
        check("mid_action_zero", in_action, 0);
        check("mid_pat_ready", pat_ready, 1);
        check("mid_pass_count", pass_count, 0);
        check("mid_fail_count", fail_count, 0);
        check("mid_proto_err", proto_err, 0);
        rv_seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (res_valid) rv_seen++;
        end
        check("mid_no_res_valid", rv_seen, 0);
        check("mid_still_idle", pat_ready, 1);

        // ---- Two-cycle out_valid response ----
        send_pattern(pa);
        repeat (47) @(negedge clk);
        repeat (3) @(negedge clk);
        out_valid = 1'b1;
        out_score = 7'd42;
        @(negedge clk);
        check("dbl_res_valid", res_valid, 1);
        check("dbl_res_pass", res_pass, 1);
        @(negedge clk);
        out_valid = 1'b0;
        out_score = 7'd0;
        check("dbl_pass_count", pass_count, 1);
        check("dbl_proto_err", proto_err, exp_proto_stray);
        repeat (5) @(negedge clk);
        check("dbl_proto_sticky", proto_err, exp_proto_stray);
        check("dbl_pass_count_hold", pass_count, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("dbl_proto_cleared", proto_err, 0);
        check("dbl_count_cleared", pass_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cc_stim_driver.md
Name: cc_stim_driver

Overview:
Synthesizable transmitter for the CC candy-board input protocol; it is the driving end of the interface that the CC core receives.
- Accepts one packed 223-bit pattern word and replays it as the 36-cycle board phase, followed by the 10-cycle action phase.
- Waits for the CC core's single-cycle score response, compares it with the expected score and keeps running pass/fail tallies.
- Used for on-chip/FPGA self-test of CC and as a reusable bench driver.

Parameters:
- GAP_CYCLES, 2, idle cycles between in_valid_1 falling and in_valid_2 rising (legal 1..15).
- TIMEOUT, 500, max cycles from in_valid_2 falling to out_valid before the pattern is declared timed out (legal 2..1023).
- CNT_W, 8, width of the pass/fail counters (saturating).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- pat_valid  in  1  pattern word offered.
- pat_ready  out  1  driver can accept a pattern (IDLE only).
- pat_data  in  223  packed pattern, MSB first:
  - [222:115] 36 colours x 3 bits
  - [114:103] 4 stripe rows x 3
  - [102:91] 4 stripe cols x 3
  - [90:87] 4 stripe types
  - [86:57] 10 action rows x 3
  - [56:27] 10 action cols x 3
  - [26:7] 10 actions x 2
  - [6:0] expected score
- in_valid_1  out  1  board phase valid.
- in_valid_2  out  1  action phase valid.
- in_color  out  3  candy colour.
- in_starting_pos  out  6  {row[2:0], col[2:0]}.
- in_stripe  out  1  stripe type.
- in_action  out  2  action code.
- out_valid  in  1  CC score strobe.
- out_score  in  7  CC score.
- res_valid  out  1  one-cycle result strobe.
- res_pass  out  1  score matched (qualified by res_valid).
- res_timeout  out  1  no response within TIMEOUT.
- res_score  out  7  captured out_score (0 on timeout).
- pass_count  out  CNT_W  saturating pass tally.
- fail_count  out  CNT_W  saturating fail tally (mismatch or timeout).
- proto_err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset (rst_n low at a rising edge, including mid-pattern):
  - state returns to IDLE;
  - every output is 0, except pat_ready, which is 1 in IDLE;
  - counters and proto_err clear;
  - a pattern in flight is discarded with no res_valid.
- Data outputs are driven 0 whenever their qualifying valid is low:
  - in_color: valid during in_valid_1;
  - in_starting_pos / in_stripe: valid during board items 0-3 or during in_valid_2;
  - in_action: valid during in_valid_2.
- States: IDLE -> CANDY -> GAP -> ACTION -> WAIT -> REPORT -> IDLE.
- IDLE:
  - pat_ready = 1;
  - pat_valid & pat_ready at edge t latches pat_data into a shadow register and moves to CANDY.
- CANDY:
  - in_valid_1 = 1 for exactly 36 cycles, edges t+1..t+36; 6-bit index i runs 0..35.
  - in_color = colour[i].
  - For i < 4: in_starting_pos = {stripe_row[i], stripe_col[i]}, in_stripe = stripe_type[i].
- GAP: all valids low for GAP_CYCLES cycles.
- ACTION:
  - in_valid_2 = 1 for exactly 10 cycles, index j = 0..9.
  - in_starting_pos = {act_row[j], act_col[j]}, in_action = action[j].
- WAIT:
  - Timeout counter starts at 0 on the first cycle after in_valid_2 falls.
  - out_valid sampled high: capture out_score, go to REPORT.
  - Counter reaches TIMEOUT without out_valid: set timeout, go to REPORT.
  - out_valid and terminal count in the same cycle: out_valid wins (pass/fail by comparison).
- REPORT: res_valid = 1 for exactly one cycle.
  - res_pass = (captured score == expected) & ~timeout; res_timeout as flagged; res_score as captured.
  - Increments pass_count or fail_count, saturating at 2^CNT_W-1.
  - The next cycle is IDLE.
- out_valid outside WAIT is ignored; the FSM is unaffected.
- pat_data is sampled only on acceptance; changes while busy have no effect.
- Back-to-back patterns: minimum spacing is one IDLE cycle after REPORT.

Optional Feature:
Macro CC_STIM_PROTO_CHECK_EN.
- With the macro, proto_err is set (sticky until reset) when any of these occur:
  - out_valid is high for 2 or more consecutive cycles;
  - out_score != 0 while out_valid is low;
  - out_valid is high in any state other than WAIT.
- Without the macro, the checker logic is absent and proto_err is tied to 0.

Test Plan:
- Reset check: hold rst_n low 2 cycles with all inputs at 0 -> every output is 0, pat_ready = 1, counters = 0.
- Timing check: accept a pattern at edge t with GAP_CYCLES = 2 ->
  - in_valid_1 high edges t+1..t+36;
  - in_valid_2 high edges t+39..t+48;
  - in_stripe and stripe positions are nonzero only at t+1..t+4;
  - every driven field matches the pattern slice.
- Correct response: responder returns out_valid pulse with out_score = 7'd42 and expected score 42 -> one res_valid, res_pass = 1, pass_count = 1.
- Mismatch: out_score = 7'd41 with expected 42 -> res_pass = 0, res_score = 41, fail_count = 1.
- Timeout: no out_valid -> res_timeout = 1 exactly TIMEOUT cycles after in_valid_2 falls, fail_count increments.
  - Second run: out_valid asserted on the terminal-count cycle -> treated as a response, not a timeout.
- Reset mid-pattern and protocol check:
  - rst_n low during ACTION j = 5 -> valids drop at the next edge, no res_valid, counters are 0.
  - With CC_STIM_PROTO_CHECK_EN: a 2-cycle out_valid sets proto_err = 1, and it holds until reset.
